// File: rtl/uriscv_csr_irq.sv
// Machine-mode CSR unit with latched/maskable external IRQs, 64-bit cycle counter and timer compare.
// Reads and trap decisions are combinational in the valid_i cycle; all state commits at the next clk_i edge.
module uriscv_csr_irq #(
  parameter int          NUM_IRQ     = 4,
  parameter bit          VECTORED    = 1'b1,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit          TIMER_EN    = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_IRQ-1:0] intr_i,
  input  logic [31:0]        cpu_id_i,
  input  logic               valid_i,
  input  logic [31:0]        pc_i,
  input  logic [31:0]        opcode_i,
  input  logic [31:0]        rs1_val_i,
  output logic [31:0]        csr_rdata_o,
  input  logic               excpn_invalid_inst_i,
  input  logic               excpn_lsu_align_i,
  input  logic [31:0]        mem_addr_i,
  output logic [31:0]        csr_mepc_o,
  output logic               exception_o,
  output logic [31:0]        exception_cause_o,
  output logic [31:0]        exception_pc_o
);

  logic               mstatus_mie_q, mstatus_mie_d;
  logic               mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0]        mie_q, mie_d;
  logic [31:0]        mtvec_q, mtvec_d;
  logic [31:0]        mscratch_q, mscratch_d;
  logic [31:0]        mepc_q, mepc_d;
  logic [31:0]        mcause_q, mcause_d;
  logic [31:0]        mtval_q, mtval_d;
  logic [63:0]        mcycle_q, mcycle_d;
  logic [63:0]        mtimecmp_q, mtimecmp_d;
  logic [NUM_IRQ-1:0] mipx_q, mipx_d;
  logic [NUM_IRQ-1:0] miex_q, miex_d;
  logic               mtip_q, mtip_d;

  // Instruction decode
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [4:0]  rs1_idx;
  logic        is_csr, is_ecall, is_ebreak, is_mret, is_store;

  assign funct3    = opcode_i[14:12];
  assign csr_addr  = opcode_i[31:20];
  assign rs1_idx   = opcode_i[19:15];
  assign is_csr    = (opcode_i[6:0] == 7'h73) && (funct3 != 3'd0) && (funct3 != 3'd4);
  assign is_ecall  = (opcode_i == 32'h0000_0073);
  assign is_ebreak = (opcode_i == 32'h0010_0073);
  assign is_mret   = (opcode_i == 32'h3020_0073);
  assign is_store  = (opcode_i[6:0] == 7'b0100011);

  // Interrupt pending/enable
  logic [NUM_IRQ-1:0] irq_vec;
  logic               meip;
  logic [31:0]        mip_val;
  logic [31:0]        irq_pend;
  logic               irq_take;
  logic [4:0]         ext_idx;
  logic [4:0]         irq_code;
  logic [31:0]        irq_cause;

  assign irq_vec  = mipx_q & miex_q;
  assign meip     = |irq_vec;
  assign mip_val  = {20'b0, meip, 3'b0, mtip_q, 7'b0};
  assign irq_pend = mie_q & mip_val;
  assign irq_take = valid_i && mstatus_mie_q && (|irq_pend);

  // Descending scan so the lowest-index pending line ends up selected
  always_comb begin
    ext_idx = 5'd0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (irq_vec[k]) ext_idx = 5'(k);
    end
  end

  assign irq_code  = 5'd16 + ext_idx;
  assign irq_cause = irq_pend[11] ? {1'b1, 26'b0, irq_code} : 32'h8000_0007;

  // Trap selection
  logic        trap;
  logic        trap_is_int;
  logic [31:0] trap_cause;
  logic [31:0] trap_tval;

  always_comb begin
    trap        = 1'b0;
    trap_is_int = 1'b0;
    trap_cause  = 32'd0;
    trap_tval   = 32'd0;
    if (valid_i) begin
      if (excpn_invalid_inst_i) begin
        trap       = 1'b1;
        trap_cause = 32'd2;
        trap_tval  = opcode_i;
      end else if (is_ebreak) begin
        trap       = 1'b1;
        trap_cause = 32'd3;
      end else if (is_ecall) begin
        trap       = 1'b1;
        trap_cause = 32'd11;
      end else if (excpn_lsu_align_i) begin
        trap       = 1'b1;
        trap_cause = is_store ? 32'd6 : 32'd4;
        trap_tval  = mem_addr_i;
      end else if (irq_take) begin
        trap        = 1'b1;
        trap_is_int = 1'b1;
        trap_cause  = irq_cause;
      end
    end
  end

  logic [31:0] tvec_base;
  assign tvec_base         = {mtvec_q[31:2], 2'b00};
  assign exception_o       = trap;
  assign exception_cause_o = trap_cause;
  assign exception_pc_o    = (VECTORED && (mtvec_q[1:0] == 2'b01) && trap_is_int)
                             ? tvec_base + {25'b0, trap_cause[4:0], 2'b00}
                             : tvec_base;
  assign csr_mepc_o        = mepc_q;

  // CSR read (pre-write value)
  logic [31:0] csr_old;
  always_comb begin
    csr_old = 32'd0;
    case (csr_addr)
      12'h300: csr_old = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
      12'h301: csr_old = 32'h4000_1100;
      12'h304: csr_old = mie_q;
      12'h305: csr_old = mtvec_q;
      12'h340: csr_old = mscratch_q;
      12'h341: csr_old = mepc_q;
      12'h342: csr_old = mcause_q;
      12'h343: csr_old = mtval_q;
      12'h344: csr_old = mip_val;
      12'hB00, 12'hC01: csr_old = mcycle_q[31:0];
      12'hB80, 12'hC81: csr_old = mcycle_q[63:32];
      12'h7C0: csr_old = mtimecmp_q[31:0];
      12'h7C1: csr_old = mtimecmp_q[63:32];
      12'h7C2: csr_old = {{(32-NUM_IRQ){1'b0}}, mipx_q};
      12'h7C3: csr_old = {{(32-NUM_IRQ){1'b0}}, miex_q};
      12'hF14: csr_old = cpu_id_i;
      default: csr_old = 32'd0;
    endcase
  end

  assign csr_rdata_o = (valid_i && is_csr) ? csr_old : 32'd0;

  // CSR write data; set/clear with rs1/uimm field of zero is a pure read
  logic [31:0] csr_src;
  logic [31:0] csr_wdata;
  logic        csr_we;
  logic        mret_take;

  assign csr_src = funct3[2] ? {27'b0, rs1_idx} : rs1_val_i;

  always_comb begin
    csr_wdata = csr_old;
    case (funct3[1:0])
      2'b01:   csr_wdata = csr_src;
      2'b10:   csr_wdata = csr_old | csr_src;
      2'b11:   csr_wdata = csr_old & ~csr_src;
      default: csr_wdata = csr_old;
    endcase
  end

  assign csr_we    = valid_i && is_csr && !trap && ((funct3[1:0] == 2'b01) || (rs1_idx != 5'd0));
  assign mret_take = valid_i && is_mret && !trap;

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    mcycle_d       = mcycle_q + 64'd1;
    mtimecmp_d     = mtimecmp_q;
    mipx_d         = mipx_q;
    miex_d         = miex_q;
    mtip_d         = TIMER_EN ? (mcycle_q >= mtimecmp_q) : 1'b0;
    if (csr_we) begin
      case (csr_addr)
        12'h300: begin
          mstatus_mie_d  = csr_wdata[3];
          mstatus_mpie_d = csr_wdata[7];
        end
        12'h304: mie_d      = csr_wdata & 32'h0000_0880;
        12'h305: mtvec_d    = csr_wdata & ~32'h0000_0002;
        12'h340: mscratch_d = csr_wdata;
        12'h341: mepc_d     = csr_wdata;
        12'h342: mcause_d   = csr_wdata;
        12'h343: mtval_d    = csr_wdata;
        12'hB00: mcycle_d   = {mcycle_q[63:32], csr_wdata};
        12'hB80: mcycle_d   = {csr_wdata, mcycle_q[31:0]};
        12'h7C0: mtimecmp_d = {mtimecmp_q[63:32], csr_wdata};
        12'h7C1: mtimecmp_d = {csr_wdata, mtimecmp_q[31:0]};
        12'h7C2: mipx_d     = csr_wdata[NUM_IRQ-1:0];
        12'h7C3: miex_d     = csr_wdata[NUM_IRQ-1:0];
        default: ;
      endcase
    end
    // A line asserted this cycle beats a software clear
    mipx_d = mipx_d | intr_i;
    if (trap) begin
      mepc_d         = pc_i;
      mcause_d       = trap_cause;
      mtval_d        = trap_tval;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_take) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'd0;
      mtvec_q        <= MTVEC_RESET & ~32'h0000_0002;
      mscratch_q     <= 32'd0;
      mepc_q         <= 32'd0;
      mcause_q       <= 32'd0;
      mtval_q        <= 32'd0;
      mcycle_q       <= 64'd0;
      mtimecmp_q     <= 64'd0;
      mipx_q         <= '0;
      miex_q         <= '0;
      mtip_q         <= 1'b0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mcycle_q       <= mcycle_d;
      mtimecmp_q     <= mtimecmp_d;
      mipx_q         <= mipx_d;
      miex_q         <= miex_d;
      mtip_q         <= mtip_d;
    end
  end

endmodule

// File: tb/tb_uriscv_csr_irq.sv
// Directed bench for uriscv_csr_irq: reset, IRQ priority/vectoring, timer, trap priority, mret, counter wrap.
module tb_uriscv_csr_irq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  intr_i;
  logic [31:0] cpu_id_i;
  logic        valid_i;
  logic [31:0] pc_i;
  logic [31:0] opcode_i;
  logic [31:0] rs1_val_i;
  logic [31:0] csr_rdata_o;
  logic        excpn_invalid_inst_i;
  logic        excpn_lsu_align_i;
  logic [31:0] mem_addr_i;
  logic [31:0] csr_mepc_o;
  logic        exception_o;
  logic [31:0] exception_cause_o;
  logic [31:0] exception_pc_o;

  int checks = 0;
  int errors = 0;

  uriscv_csr_irq #(
    .NUM_IRQ    (4),
    .VECTORED   (1'b1),
    .MTVEC_RESET(32'h0000_0100),
    .TIMER_EN   (1'b1)
  ) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .intr_i              (intr_i),
    .cpu_id_i            (cpu_id_i),
    .valid_i             (valid_i),
    .pc_i                (pc_i),
    .opcode_i            (opcode_i),
    .rs1_val_i           (rs1_val_i),
    .csr_rdata_o         (csr_rdata_o),
    .excpn_invalid_inst_i(excpn_invalid_inst_i),
    .excpn_lsu_align_i   (excpn_lsu_align_i),
    .mem_addr_i          (mem_addr_i),
    .csr_mepc_o          (csr_mepc_o),
    .exception_o         (exception_o),
    .exception_cause_o   (exception_cause_o),
    .exception_pc_o      (exception_pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] csr_ins(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs1);
    return {a, rs1, f3, 5'd1, 7'h73};
  endfunction

  task automatic issue(input logic [31:0] op, input logic [31:0] pc, input logic [31:0] rs1);
    valid_i   = 1'b1;
    opcode_i  = op;
    pc_i      = pc;
    rs1_val_i = rs1;
    #1;
  endtask

  task automatic commit();
    @(posedge clk_i);
    #1;
    valid_i              = 1'b0;
    opcode_i             = 32'd0;
    pc_i                 = 32'd0;
    rs1_val_i            = 32'd0;
    excpn_invalid_inst_i = 1'b0;
    excpn_lsu_align_i    = 1'b0;
    mem_addr_i           = 32'd0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] v);
    issue(csr_ins(3'd1, a, 5'd2), 32'd0, v);
    commit();
  endtask

  task automatic chk_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
    issue(csr_ins(3'd2, a, 5'd0), 32'd0, 32'd0);
    chk(tag, csr_rdata_o, exp);
    commit();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bad_op;
    rst_i                = 1'b1;
    intr_i               = 4'd0;
    cpu_id_i             = 32'hCAFE_0001;
    valid_i              = 1'b0;
    pc_i                 = 32'd0;
    opcode_i             = 32'd0;
    rs1_val_i            = 32'd0;
    excpn_invalid_inst_i = 1'b0;
    excpn_lsu_align_i    = 1'b0;
    mem_addr_i           = 32'd0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Reset state
    chk("rst_exc", {31'b0, exception_o}, 32'd0);
    chk("rst_rdata", csr_rdata_o, 32'd0);
    chk("rst_mepc", csr_mepc_o, 32'd0);
    chk("rst_expc", exception_pc_o, 32'h100);
    repeat (5) @(posedge clk_i);
    #1;
    chk_csr("mcycle5", 12'hB00, 32'd5);
    chk_csr("mtvec_rst", 12'h305, 32'h100);
    chk_csr("mstatus_rst", 12'h300, 32'h1800);
    chk_csr("misa", 12'h301, 32'h4000_1100);
    chk_csr("mhartid", 12'hF14, 32'hCAFE_0001);
    chk_csr("unmapped", 12'h7FF, 32'd0);

    // Vectored external interrupt on line 2
    csr_wr(12'h305, 32'h201);
    csr_wr(12'h304, 32'h800);
    csr_wr(12'h7C3, 32'h6);
    csr_wr(12'h300, 32'h8);
    intr_i = 4'b0100;
    @(posedge clk_i);
    #1;
    intr_i = 4'b0000;
    issue(32'h0000_0013, 32'h40, 32'd0);
    chk("irq2_exc", {31'b0, exception_o}, 32'd1);
    chk("irq2_cause", exception_cause_o, 32'h8000_0012);
    chk("irq2_pc", exception_pc_o, 32'h248);
    commit();
    chk("irq2_mepc", csr_mepc_o, 32'h40);
    chk_csr("irq2_mstatus", 12'h300, 32'h1880);
    chk_csr("irq2_mcause", 12'h342, 32'h8000_0012);

    // Two lines pending: lowest index first, then clear it
    intr_i = 4'b0010;
    @(posedge clk_i);
    #1;
    intr_i = 4'b0000;
    chk_csr("mipx_both", 12'h7C2, 32'h6);
    csr_wr(12'h300, 32'h8);
    issue(32'h0000_0013, 32'h80, 32'd0);
    chk("irq1_cause", exception_cause_o, 32'h8000_0011);
    chk("irq1_pc", exception_pc_o, 32'h244);
    commit();
    issue(csr_ins(3'd3, 12'h7C2, 5'd2), 32'd0, 32'h2);
    commit();
    chk_csr("mipx_clr1", 12'h7C2, 32'h4);
    csr_wr(12'h300, 32'h8);
    issue(32'h0000_0013, 32'h84, 32'd0);
    chk("irq2b_cause", exception_cause_o, 32'h8000_0012);
    commit();
    issue(csr_ins(3'd3, 12'h7C2, 5'd2), 32'd0, 32'hF);
    commit();
    chk_csr("mip_tonly", 12'h344, 32'h80);

    // Timer compare, direct mode
    csr_wr(12'h305, 32'h300);
    csr_wr(12'h304, 32'h80);
    csr_wr(12'h7C1, 32'd1);
    csr_wr(12'h7C0, 32'd20);
    chk_csr("mtip_off", 12'h344, 32'd0);
    csr_wr(12'h7C1, 32'd0);
    chk_csr("mtip_lag", 12'h344, 32'd0);
    chk_csr("mtip_on", 12'h344, 32'h80);
    csr_wr(12'h300, 32'h8);
    issue(32'h0000_0013, 32'h90, 32'd0);
    chk("tmr_cause", exception_cause_o, 32'h8000_0007);
    chk("tmr_pc", exception_pc_o, 32'h300);
    commit();
    csr_wr(12'h7C1, 32'd1);
    @(posedge clk_i);
    #1;
    chk_csr("mtip_clr", 12'h344, 32'd0);

    // Trap priority; suppressed CSR write
    bad_op = csr_ins(3'd1, 12'h340, 5'd2);
    excpn_invalid_inst_i = 1'b1;
    excpn_lsu_align_i    = 1'b1;
    mem_addr_i           = 32'h1234;
    issue(bad_op, 32'hA0, 32'h0000_DEAD);
    chk("ill_exc", {31'b0, exception_o}, 32'd1);
    chk("ill_cause", exception_cause_o, 32'd2);
    chk("ill_pc", exception_pc_o, 32'h300);
    commit();
    chk_csr("ill_mcause", 12'h342, 32'd2);
    chk_csr("ill_mtval", 12'h343, bad_op);
    chk_csr("ill_mscratch", 12'h340, 32'd0);
    excpn_lsu_align_i = 1'b1;
    issue(32'h0000_0073, 32'hB0, 32'd0);
    chk("ecall_cause", exception_cause_o, 32'd11);
    commit();
    excpn_lsu_align_i = 1'b1;
    mem_addr_i        = 32'h5678;
    issue(32'h0000_2023, 32'hB4, 32'd0);
    chk("st_cause", exception_cause_o, 32'd6);
    commit();
    chk_csr("st_mtval", 12'h343, 32'h5678);
    excpn_lsu_align_i = 1'b1;
    issue(32'h0000_2003, 32'hB8, 32'd0);
    chk("ld_cause", exception_cause_o, 32'd4);
    commit();

    // mret
    csr_wr(12'h300, 32'h8);
    issue(32'h0000_0073, 32'hC0, 32'd0);
    chk("ecall2_cause", exception_cause_o, 32'd11);
    commit();
    issue(32'h3020_0073, 32'hC4, 32'd0);
    chk("mret_exc", {31'b0, exception_o}, 32'd0);
    commit();
    chk_csr("mret_mstatus", 12'h300, 32'h1888);
    chk("mret_mepc", csr_mepc_o, 32'hC0);

    // mcycle wrap
    csr_wr(12'h304, 32'd0);
    csr_wr(12'hB80, 32'hFFFF_FFFF);
    csr_wr(12'hB00, 32'hFFFF_FFFF);
    chk_csr("wrap_hi_pre", 12'hB80, 32'hFFFF_FFFF);
    chk_csr("wrap_lo", 12'hB00, 32'd0);
    chk_csr("wrap_hi", 12'hC81, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
